// File: rtl/fc8_mem_ctrl.sv
// fc8_mem_ctrl: byte-wide RAM plus bus controller for the FC8 CPU memory port.
//
// A bus request (bus_rd_en/bus_wr_en, held by the CPU until bus_ready) is
// sampled in IDLE. After WAIT_STATES extra cycles the array is accessed, and
// a registered one-cycle bus_ready pulse follows. The 16-bit CPU address is
// mirrored onto the 2^ADDR_W array by dropping the upper bits, so the
// $FFFA-$FFFF vectors land at the top of the RAM.
//
// Parameters:
//   ADDR_W       array address width, depth = 2^ADDR_W bytes (1..16)
//   WAIT_STATES  extra cycles before the access (0..15)
//   ROM_BASE     first write-protected physical address (protect build only)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bus_addr/wdata     CPU address and write data
//   bus_rd_en/wr_en    request strobes, held until bus_ready
//   bus_rdata          last read data, held between reads
//   bus_ready          one-cycle completion pulse
//   bus_err            pulses with bus_ready when rd and wr were both requested
//   wr_fault           pulses with bus_ready on a blocked protected write
//   busy               high while a request is in WAIT or ACK
//   ld_en/addr/data    backdoor preload port, usable in any state
//
// Build option: define FC8_MEM_ROM_PROTECT_EN to block bus writes at or
// above ROM_BASE (backdoor writes are never blocked).

module fc8_mem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0,
  parameter int ROM_BASE    = 'h300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_addr,
  input  logic [7:0]        bus_wdata,
  input  logic              bus_rd_en,
  input  logic              bus_wr_en,
  output logic [7:0]        bus_rdata,
  output logic              bus_ready,
  output logic              bus_err,
  output logic              wr_fault,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [3:0] wcnt, wcnt_nx;

  logic [7:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] phys;
  logic              req;
  logic              sample;

  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_wdata;
  logic              lat_wr;
  logic              lat_err;

  // Access performed on the edge entering ACK. With zero wait states that edge
  // is the sampling edge itself, so the fields come straight from the bus.
  logic              acc_en;
  logic              acc_commit;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_wr;
  logic              acc_blk;
  logic              lat_blk;
  logic              unused_bits;

  assign phys = bus_addr[ADDR_W-1:0];
  assign req  = bus_rd_en | bus_wr_en;
  // bus_ready high means the CPU is still holding the request it just had
  // completed; ignoring it for that cycle prevents a duplicate access.
  assign sample = (state == S_IDLE) && req && !bus_ready;
  assign busy = (state != S_IDLE);

`ifdef FC8_MEM_ROM_PROTECT_EN
  assign acc_blk = (32'(acc_addr) >= ROM_BASE);
  assign lat_blk = (32'(lat_addr) >= ROM_BASE);
  assign unused_bits = ^{bus_addr};
`else
  assign acc_blk = 1'b0;
  assign lat_blk = 1'b0;
  assign unused_bits = ^{bus_addr, 32'(ROM_BASE)};
`endif

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    acc_en    = 1'b0;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_wr    = lat_wr;
    case (state)
      S_IDLE: begin
        if (sample) begin
          wcnt_nx = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_nx  = S_ACK;
            acc_en    = 1'b1;
            acc_addr  = phys;
            acc_wdata = bus_wdata;
            acc_wr    = bus_wr_en;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else begin
          wcnt_nx = wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state_nx = S_ACK;
            acc_en   = 1'b1;
          end
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Reset on the access edge still discards the operation.
  assign acc_commit = acc_en && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= 8'd0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      bus_rdata <= 8'd0;
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      wr_fault  <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      bus_ready <= (state == S_ACK);
      bus_err   <= (state == S_ACK) && lat_err;
      wr_fault  <= (state == S_ACK) && lat_wr && lat_blk;
      if (sample) begin
        lat_addr  <= phys;
        lat_wdata <= bus_wdata;
        lat_wr    <= bus_wr_en;
        lat_err   <= bus_rd_en && bus_wr_en;
      end
      if (acc_commit && !acc_wr)
        bus_rdata <= mem[acc_addr];
    end
  end

  // Array is not reset. The backdoor assignment comes last so it wins a
  // same-address collision with a bus write commit.
  always_ff @(posedge clk) begin
    if (acc_commit && acc_wr && !acc_blk)
      mem[acc_addr] <= acc_wdata;
    if (ld_en)
      mem[ld_addr] <= ld_data;
  end

endmodule
